// File: rtl/natv_apb_pkg.sv
// Shared types and constants for the native-bus to APB bridge family.
// Holds the FSM state encoding, default sizing and the error read pattern.
package natv_apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam int unsigned NSLV_DEF     = 8;
   localparam int unsigned SEL_W        = $clog2(NSLV_DEF);
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

   // Select-index width, never below one bit so ports stay legal
   function automatic int unsigned sel_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/natv_apb_dec.sv
// Combinational window decoder: hit test, slave index, one-hot select and
// word-aligned offset within the selected slave region.
module natv_apb_dec
   import natv_apb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
   parameter int unsigned NSLV        = NSLV_DEF,
   parameter int unsigned SLV_SEL_LSB = 12,
   localparam int unsigned SW         = sel_width(NSLV)
) (
   input  logic [31:0]            addr_i,
   output logic                   hit_o,
   output logic [SW-1:0]          idx_o,
   output logic [NSLV-1:0]        onehot_o,
   output logic [SLV_SEL_LSB-1:0] paddr_o
);

   localparam int unsigned TAG_LSB = SLV_SEL_LSB + SW;
   localparam logic [SLV_SEL_LSB-1:0] WORD_MASK = {{(SLV_SEL_LSB-2){1'b1}}, 2'b00};

   assign hit_o   = (addr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
   assign idx_o   = addr_i[SLV_SEL_LSB +: SW];
   assign paddr_o = addr_i[SLV_SEL_LSB-1:0] & WORD_MASK;

   generate
      for (genvar gi = 0; gi < NSLV; gi++) begin : g_onehot
         assign onehot_o[gi] = (idx_o == SW'(gi));
      end
   endgenerate

endmodule

// File: rtl/natv_apb_bridge.sv
// Native valid/ready responder bridging into an APB initiator with NSLV selects.
// One ready pulse per request; decode miss, PSLVERR and timeout return ERR_DATA.
module natv_apb_bridge
   import natv_apb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
   parameter int unsigned NSLV        = NSLV_DEF,
   parameter int unsigned SLV_SEL_LSB = 12,
   parameter int unsigned TIMEOUT     = 255,
   parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   natv_valid_i,
   input  logic [31:0]            natv_addr_i,
   input  logic [31:0]            natv_wdata_i,
   input  logic [3:0]             natv_wstrb_i,
   output logic [31:0]            natv_rdata_o,
   output logic                   natv_ready_o,
   output logic [SLV_SEL_LSB-1:0] apb_paddr_o,
   output logic [31:0]            apb_pwdata_o,
   output logic [3:0]             apb_pstrb_o,
   output logic                   apb_pwrite_o,
   output logic [NSLV-1:0]        apb_psel_o,
   output logic                   apb_penable_o,
   input  logic [NSLV*32-1:0]     apb_prdata_i,
   input  logic [NSLV-1:0]        apb_pready_i,
   input  logic [NSLV-1:0]        apb_pslverr_i,
   output logic                   err_o
);

   localparam int unsigned SW       = sel_width(NSLV);
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   logic                   dec_hit;
   logic [SW-1:0]          dec_idx;
   logic [NSLV-1:0]        dec_onehot;
   logic [SLV_SEL_LSB-1:0] dec_paddr;

   state_e                 state_q, state_d;
   logic [SLV_SEL_LSB-1:0] paddr_q, paddr_d;
   logic [31:0]            pwdata_q, pwdata_d;
   logic [3:0]             pstrb_q, pstrb_d;
   logic [SW-1:0]          idx_q, idx_d;
   logic [NSLV-1:0]        psel_q, psel_d;
   logic                   penable_q, penable_d;
   logic                   ready_q, ready_d;
   logic                   err_q, err_d;
   logic [31:0]            rdata_q, rdata_d;
   logic [15:0]            cnt_q, cnt_d;

   logic [31:0]            prdata_arr [NSLV];
   logic [31:0]            sel_prdata;
   logic                   sel_pready;
   logic                   sel_pslverr;
   logic                   pwrite;

   natv_apb_dec #(
      .BASE_ADDR   (BASE_ADDR),
      .NSLV        (NSLV),
      .SLV_SEL_LSB (SLV_SEL_LSB)
   ) u_dec (
      .addr_i   (natv_addr_i),
      .hit_o    (dec_hit),
      .idx_o    (dec_idx),
      .onehot_o (dec_onehot),
      .paddr_o  (dec_paddr)
   );

   generate
      for (genvar gi = 0; gi < NSLV; gi++) begin : g_prdata
         assign prdata_arr[gi] = apb_prdata_i[32*gi +: 32];
      end
   endgenerate

   // Only the latched target slave is ever listened to
   assign sel_prdata  = prdata_arr[idx_q];
   assign sel_pready  = apb_pready_i[idx_q];
   assign sel_pslverr = apb_pslverr_i[idx_q];
   assign pwrite      = |pstrb_q;

   always_comb begin
      state_d   = state_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pstrb_d   = pstrb_q;
      idx_d     = idx_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      ready_d   = 1'b0;
      err_d     = 1'b0;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_IDLE: begin
            rdata_d = '0;
            if (natv_valid_i) begin
               if (dec_hit) begin
                  paddr_d  = dec_paddr;
                  pwdata_d = natv_wdata_i;
                  pstrb_d  = natv_wstrb_i;
                  idx_d    = dec_idx;
                  psel_d   = dec_onehot;
                  state_d  = ST_SETUP;
               end else begin
                  rdata_d = ERR_DATA;
                  err_d   = 1'b1;
                  ready_d = 1'b1;
                  state_d = ST_RESP;
               end
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            cnt_d = cnt_q + 16'd1;
            // pready has priority over an expiring counter in the same cycle
            if (sel_pready || (cnt_q == CNT_LAST)) begin
               psel_d    = '0;
               penable_d = 1'b0;
               ready_d   = 1'b1;
               state_d   = ST_RESP;
               if (!sel_pready || sel_pslverr) begin
                  rdata_d = ERR_DATA;
                  err_d   = 1'b1;
               end else if (pwrite) begin
                  rdata_d = '0;
               end else begin
                  rdata_d = sel_prdata;
               end
            end
         end
         ST_RESP: begin
            cnt_d   = '0;
            rdata_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            psel_d    = '0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         idx_q     <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         idx_q     <= idx_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         cnt_q     <= cnt_d;
      end
   end

   assign natv_rdata_o  = rdata_q;
   assign natv_ready_o  = ready_q;
   assign err_o         = err_q;
   assign apb_paddr_o   = paddr_q;
   assign apb_pwdata_o  = pwdata_q;
   assign apb_pstrb_o   = pstrb_q;
   assign apb_pwrite_o  = pwrite;
   assign apb_psel_o    = psel_q;
   assign apb_penable_o = penable_q;

endmodule

// File: tb/tb_natv_apb_bridge.sv
// Scoreboard bench for natv_apb_bridge: directed requests push expected
// responses, a negedge monitor checks APB phases and each ready pulse.
module tb_natv_apb_bridge;

   localparam int NSLV = 8;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [7:0]  lat;
      logic        apb;
      logic [7:0]  psel;
      logic [11:0] paddr;
      logic        pwrite;
      logic [3:0]  pstrb;
      logic [31:0] pwdata;
      logic [7:0]  acc;
   } exp_t;

   logic              clk_i = 1'b0;
   logic              rst_n_i = 1'b0;
   logic              natv_valid_i = 1'b0;
   logic [31:0]       natv_addr_i = '0;
   logic [31:0]       natv_wdata_i = '0;
   logic [3:0]        natv_wstrb_i = '0;
   logic [31:0]       natv_rdata_o;
   logic              natv_ready_o;
   logic [11:0]       apb_paddr_o;
   logic [31:0]       apb_pwdata_o;
   logic [3:0]        apb_pstrb_o;
   logic              apb_pwrite_o;
   logic [NSLV-1:0]   apb_psel_o;
   logic              apb_penable_o;
   logic [NSLV*32-1:0] apb_prdata_i;
   logic [NSLV-1:0]   apb_pready_i;
   logic [NSLV-1:0]   apb_pslverr_i;
   logic              err_o;

   logic [31:0] cfg_data [NSLV];
   int          cfg_wait [NSLV];
   logic        cfg_err  [NSLV];
   int          acc_cnt = 0;
   int          cyc = 0;
   bit          mon_en = 1'b0;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];

   always #5 clk_i = ~clk_i;

   natv_apb_bridge #(.TIMEOUT(16)) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .natv_valid_i  (natv_valid_i),
      .natv_addr_i   (natv_addr_i),
      .natv_wdata_i  (natv_wdata_i),
      .natv_wstrb_i  (natv_wstrb_i),
      .natv_rdata_o  (natv_rdata_o),
      .natv_ready_o  (natv_ready_o),
      .apb_paddr_o   (apb_paddr_o),
      .apb_pwdata_o  (apb_pwdata_o),
      .apb_pstrb_o   (apb_pstrb_o),
      .apb_pwrite_o  (apb_pwrite_o),
      .apb_psel_o    (apb_psel_o),
      .apb_penable_o (apb_penable_o),
      .apb_prdata_i  (apb_prdata_i),
      .apb_pready_i  (apb_pready_i),
      .apb_pslverr_i (apb_pslverr_i),
      .err_o         (err_o)
   );

   // Slave models; unselected slaves shout pready/pslverr to prove they are ignored
   always_comb begin
      apb_prdata_i  = '0;
      apb_pready_i  = '0;
      apb_pslverr_i = '0;
      for (int k = 0; k < NSLV; k++) begin
         apb_prdata_i[32*k +: 32] = cfg_data[k];
         if (apb_psel_o[k]) begin
            apb_pready_i[k]  = apb_penable_o && (acc_cnt >= cfg_wait[k]);
            apb_pslverr_i[k] = cfg_err[k];
         end else begin
            apb_pready_i[k]  = 1'b1;
            apb_pslverr_i[k] = 1'b1;
         end
      end
   end

   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      if (apb_penable_o && !(|(apb_psel_o & apb_pready_i)))
         acc_cnt <= acc_cnt + 1;
      else
         acc_cnt <= 0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                               input logic apb, input logic [7:0] psel, input logic [11:0] paddr,
                               input logic pwrite, input logic [3:0] pstrb,
                               input logic [31:0] pwdata, input int acc);
      exp_t e;
      e.rdata = rdata;  e.err = err;      e.lat = 8'(lat);   e.apb = apb;
      e.psel = psel;    e.paddr = paddr;  e.pwrite = pwrite; e.pstrb = pstrb;
      e.pwdata = pwdata; e.acc = 8'(acc);
      return e;
   endfunction

   task automatic wait_ready();
      int n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!natv_ready_o && n < 100);
      if (!natv_ready_o) begin
         checks++;
         errors++;
         $display("FAIL ready_wait: got no ready within %0d cycles, required a ready pulse", n);
      end
   endtask

   // Called just after a posedge; leaves valid high afterwards when hold is set
   task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input exp_t e, input bit hold);
      exp_q.push_back(e);
      natv_addr_i  = a;
      natv_wdata_i = wd;
      natv_wstrb_i = ws;
      natv_valid_i = 1'b1;
      wait_ready();
      @(posedge clk_i);
      #1;
      if (!hold) natv_valid_i = 1'b0;
   endtask

   // Monitor
   initial begin : monitor
      bit   busy = 1'b0;
      bit   in_apb = 1'b0;
      bit   saw_apb = 1'b0;
      int   start = 0;
      int   acc = 0;
      int   ntxn = 0;
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (!mon_en || !rst_n_i) begin
            busy = 1'b0;
            in_apb = 1'b0;
         end else begin
            if (!busy && natv_valid_i) begin
               busy = 1'b1;
               start = cyc;
               saw_apb = 1'b0;
               acc = 0;
            end
            if (apb_psel_o != '0) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_psel", 32'(apb_psel_o), 32'h0);
               end else begin
                  e = exp_q[0];
                  chk("psel",    32'(apb_psel_o),    32'(e.psel));
                  chk("paddr",   32'(apb_paddr_o),   32'(e.paddr));
                  chk("pwrite",  32'(apb_pwrite_o),  32'(e.pwrite));
                  chk("pstrb",   32'(apb_pstrb_o),   32'(e.pstrb));
                  chk("pwdata",  apb_pwdata_o,       e.pwdata);
                  chk("penable", 32'(apb_penable_o), 32'(in_apb));
                  if (apb_penable_o) acc++;
                  saw_apb = 1'b1;
               end
            end else begin
               chk("penable_idle", 32'(apb_penable_o), 32'h0);
            end
            in_apb = (apb_psel_o != '0);
            if (natv_ready_o) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_ready", 32'(natv_ready_o), 32'h0);
               end else begin
                  e = exp_q.pop_front();
                  chk("rdata",   natv_rdata_o,  e.rdata);
                  chk("err_o",   32'(err_o),    32'(e.err));
                  chk("latency", 32'(cyc - start), 32'(e.lat));
                  chk("apb_seen", 32'(saw_apb), 32'(e.apb));
                  chk("access_cycles", 32'(acc), 32'(e.acc));
                  ntxn++;
                  $display("txn %0d: addr=0x%08h wstrb=%b rdata=0x%08h err=%0b latency=%0d access=%0d",
                           ntxn, natv_addr_i, natv_wstrb_i, natv_rdata_o, err_o, cyc - start, acc);
               end
               busy = 1'b0;
            end else begin
               chk("err_without_ready", 32'(err_o), 32'h0);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1);
   end

   initial begin : stimulus
      int n;
      for (int k = 0; k < NSLV; k++) begin
         cfg_data[k] = 32'hC0DE_0000 + 32'(k);
         cfg_wait[k] = 0;
         cfg_err[k]  = 1'b0;
      end
      cfg_data[2] = 32'h1234_5678;
      cfg_data[4] = 32'h4444_0004;

      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_ready",   32'(natv_ready_o),  32'h0);
      chk("rst_rdata",   natv_rdata_o,       32'h0);
      chk("rst_err",     32'(err_o),         32'h0);
      chk("rst_psel",    32'(apb_psel_o),    32'h0);
      chk("rst_penable", 32'(apb_penable_o), 32'h0);
      chk("rst_paddr",   32'(apb_paddr_o),   32'h0);
      chk("rst_pwrite",  32'(apb_pwrite_o),  32'h0);
      chk("rst_pstrb",   32'(apb_pstrb_o),   32'h0);
      rst_n_i = 1'b1;
      mon_en  = 1'b1;
      @(posedge clk_i);
      #1;

      // Zero-wait read, slave 2
      txn(32'h0300_2010, 32'h0, 4'h0,
          mk(32'h1234_5678, 1'b0, 3, 1'b1, 8'h04, 12'h010, 1'b0, 4'h0, 32'h0, 1), 1'b0);
      // Write with 4 wait states, slave 5
      cfg_wait[5] = 4;
      txn(32'h0300_5004, 32'hA5A5_0000, 4'b1100,
          mk(32'h0, 1'b0, 7, 1'b1, 8'h20, 12'h004, 1'b1, 4'b1100, 32'hA5A5_0000, 5), 1'b0);
      cfg_wait[5] = 0;
      // PSLVERR on slave 0, unaligned address at the top of the region
      cfg_err[0] = 1'b1;
      txn(32'h0300_0FFE, 32'h0, 4'h0,
          mk(32'hDEAD_BEEF, 1'b1, 3, 1'b1, 8'h01, 12'hFFC, 1'b0, 4'h0, 32'h0, 1), 1'b0);
      cfg_err[0] = 1'b0;
      // Timeout on slave 3, then normal read of slave 4
      cfg_wait[3] = 1000;
      txn(32'h0300_3008, 32'h0, 4'h0,
          mk(32'hDEAD_BEEF, 1'b1, 18, 1'b1, 8'h08, 12'h008, 1'b0, 4'h0, 32'h0, 16), 1'b0);
      cfg_wait[3] = 0;
      txn(32'h0300_4000, 32'h0, 4'h0,
          mk(32'h4444_0004, 1'b0, 3, 1'b1, 8'h10, 12'h000, 1'b0, 4'h0, 32'h0, 1), 1'b0);
      // Decode misses: far away, just above and just below the window
      txn(32'h0400_0000, 32'h0, 4'h0, mk(32'hDEAD_BEEF, 1'b1, 1, 1'b0, 8'h0, 12'h0, 1'b0, 4'h0, 32'h0, 0), 1'b0);
      txn(32'h0300_8000, 32'h0, 4'h0, mk(32'hDEAD_BEEF, 1'b1, 1, 1'b0, 8'h0, 12'h0, 1'b0, 4'h0, 32'h0, 0), 1'b0);
      txn(32'h02FF_FFFC, 32'h0, 4'hF, mk(32'hDEAD_BEEF, 1'b1, 1, 1'b0, 8'h0, 12'h0, 1'b0, 4'h0, 32'h0, 0), 1'b0);
      // Zero-wait write returns 0 even though the slave drives prdata
      txn(32'h0300_1020, 32'h0BAD_F00D, 4'b1111,
          mk(32'h0, 1'b0, 3, 1'b1, 8'h02, 12'h020, 1'b1, 4'hF, 32'h0BAD_F00D, 1), 1'b0);
      // Write with PSLVERR on slave 7
      cfg_err[7] = 1'b1;
      txn(32'h0300_7100, 32'h0000_0011, 4'b0001,
          mk(32'hDEAD_BEEF, 1'b1, 3, 1'b1, 8'h80, 12'h100, 1'b1, 4'b0001, 32'h0000_0011, 1), 1'b0);
      cfg_err[7] = 1'b0;
      // Back-to-back reads with valid held across RESP
      txn(32'h0300_6100, 32'h0, 4'h0,
          mk(32'hC0DE_0006, 1'b0, 3, 1'b1, 8'h40, 12'h100, 1'b0, 4'h0, 32'h0, 1), 1'b1);
      txn(32'h0300_7FFC, 32'h0, 4'h0,
          mk(32'hC0DE_0007, 1'b0, 3, 1'b1, 8'h80, 12'hFFC, 1'b0, 4'h0, 32'h0, 1), 1'b0);

      // Reset during ACCESS
      mon_en = 1'b0;
      cfg_wait[1] = 10;
      natv_addr_i  = 32'h0300_1000;
      natv_wstrb_i = 4'h0;
      natv_wdata_i = 32'h0;
      natv_valid_i = 1'b1;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!apb_penable_o && n < 20);
      chk("reach_access", 32'(apb_penable_o), 32'h1);
      @(posedge clk_i);
      #2;
      rst_n_i = 1'b0;
      #1;
      chk("async_psel",    32'(apb_psel_o),    32'h0);
      chk("async_penable", 32'(apb_penable_o), 32'h0);
      chk("async_ready",   32'(natv_ready_o),  32'h0);
      natv_valid_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      cfg_wait[1] = 0;
      @(posedge clk_i);
      #1;
      mon_en = 1'b1;
      txn(32'h0300_2018, 32'h0, 4'h0,
          mk(32'h1234_5678, 1'b0, 3, 1'b1, 8'h04, 12'h018, 1'b0, 4'h0, 32'h0, 1), 1'b0);

      repeat (4) @(posedge clk_i);
      #1;
      chk("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
